// File: rtl/coder_pkg.sv
// Shared constants and types for the coder/interleaver datapath blocks.
package coder_pkg;
  localparam int BLK_MAX   = 6144;
  localparam int BLK_SMALL = 1056;
  localparam int W         = 8;
  localparam int N_MAX     = BLK_MAX / W;    // 768 bytes
  localparam int N_SMALL   = BLK_SMALL / W;  // 132 bytes
  localparam int CNT_W     = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
endpackage

// File: rtl/block_serializer.sv
// Parallel-load, byte-wide streaming unloader for one 1056- or 6144-bit code block.
// Build option: define SERIALIZER_BITREV_EN to emit each byte MSB-first (earliest bit on byte_out[W-1]).
module block_serializer
  import coder_pkg::*;
#(
  parameter int BLK_MAX   = coder_pkg::BLK_MAX,
  parameter int BLK_SMALL = coder_pkg::BLK_SMALL,
  parameter int W         = coder_pkg::W
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               load,
  input  logic               size_sel,
  input  logic [BLK_MAX-1:0] d_in,
  output logic               load_ready,
  output logic [W-1:0]       byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               last,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LAST_MAX   = CNT_W'(BLK_MAX / W - 1);
  localparam logic [CNT_W-1:0] LAST_SMALL = CNT_W'(BLK_SMALL / W - 1);

  ser_state_t         state, state_nxt;
  logic [BLK_MAX-1:0] blk_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               big_q;
  logic               accept;
  logic               capture;

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = b[W-1-k];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (aclr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    load_ready = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        capture    = load;
        if (load) state_nxt = SHIFT;
      end
      SHIFT: begin
        accept     = byte_ready;
        load_ready = last && byte_ready;
        capture    = load && last && byte_ready;
        // Reload on the final accept keeps back-to-back blocks gapless.
        if (accept && last && !load) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      blk_q <= '0;
      cnt_q <= '0;
      big_q <= 1'b0;
    end else if (capture) begin
      // Small blocks zero the unused upper region so nothing stale drifts down.
      blk_q <= size_sel ? d_in
                        : {{(BLK_MAX-BLK_SMALL){1'b0}}, d_in[BLK_SMALL-1:0]};
      cnt_q <= '0;
      big_q <= size_sel;
    end else if (accept) begin
      blk_q <= blk_q >> W;
      cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign byte_valid = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign last       = (state == SHIFT) && (cnt_q == (big_q ? LAST_MAX : LAST_SMALL));

`ifdef SERIALIZER_BITREV_EN
  assign byte_out = bitrev(blk_q[W-1:0]);
`else
  assign byte_out = blk_q[W-1:0];
`endif

endmodule
